// File: rtl/c16_snd_pkg.sv
// Shared register-select codes, waveform codes and LFSR constants for the c16 sound unit.
package c16_snd_pkg;

  typedef enum logic [1:0] {
    P_PERIOD  = 2'd0,
    P_VOLWAVE = 2'd1,
    P_DUR     = 2'd2,
    P_CTRL    = 2'd3
  } param_e;

  typedef enum logic [1:0] {
    W_SQUARE     = 2'd0,
    W_PULSE      = 2'd1,
    W_NOISE      = 2'd2,
    W_SQUARE_ALT = 2'd3
  } wave_e;

  localparam logic [14:0] LFSR_SEED = 15'h0001;
  // Feedback from bits 14 and 13 gives the x^15 + x^14 + 1 polynomial.
  localparam logic [14:0] LFSR_TAPS = 15'h6000;

  function automatic logic [14:0] lfsr_adv(input logic [14:0] s);
    return {s[13:0], ^(s & LFSR_TAPS)};
  endfunction

  function automatic logic wave_level(input logic [1:0] wave, input logic [1:0] step,
                                      input logic noise_bit);
    case (wave)
      W_PULSE: return (step == 2'd3);
      W_NOISE: return noise_bit;
      default: return step[0];
    endcase
  endfunction

endpackage

// File: rtl/c16_snd_if.sv
// CPU-side sound write port: one-cycle strobe with register select, channel index and data.
interface c16_snd_if;
  logic        snd_wen;
  logic [1:0]  w_param;
  logic [10:0] w_index;
  logic [15:0] w_val;

  modport master (output snd_wen, w_param, w_index, w_val);
  modport slave  (input  snd_wen, w_param, w_index, w_val);
endinterface

// File: rtl/c16_snd_channel.sv
// One tone channel: config registers, phase/step generator, noise LFSR and duration timer.
module c16_snd_channel
  import c16_snd_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        wr,
  input  param_e      param,
  input  logic [15:0] wdata,
  input  logic        tone_stb,
  input  logic        tick_stb,
  output logic        level,
  output logic        active,
  output logic        done,
  output logic [3:0]  vol
);

  logic [15:0] period, dur, phase_cnt, dur_cnt;
  logic [1:0]  wave, step;
  logic [14:0] lfsr, lfsr_nxt;
  logic        start, stop;

  assign lfsr_nxt = lfsr_adv(lfsr);
  assign start    = wr && (param == P_CTRL) && wdata[0] && !wdata[1];
  assign stop     = wr && (param == P_CTRL) && wdata[1];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      period    <= '0;
      dur       <= '0;
      phase_cnt <= '0;
      dur_cnt   <= '0;
      wave      <= '0;
      step      <= '0;
      vol       <= '0;
      lfsr      <= LFSR_SEED;
      level     <= 1'b0;
      active    <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (wr && param == P_PERIOD) period <= wdata;
      if (wr && param == P_VOLWAVE) begin
        vol  <= wdata[3:0];
        wave <= wdata[5:4];
      end
      if (wr && param == P_DUR) dur <= wdata;

      if (tone_stb && active) begin
        if (period == '0) begin
          level <= 1'b0;
        end else if (phase_cnt != '0) begin
          phase_cnt <= phase_cnt - 16'd1;
        end else begin
          phase_cnt <= period - 16'd1;
          step      <= step + 2'd1;
          lfsr      <= lfsr_nxt;
          level     <= wave_level(wave, step + 2'd1, lfsr_nxt[0]);
        end
      end

      // dur_cnt==0 with an active channel means the note was started untimed.
      if (tick_stb && active && dur != '0 && dur_cnt != '0) begin
        dur_cnt <= dur_cnt - 16'd1;
        if (dur_cnt == 16'd1) begin
          active <= 1'b0;
          level  <= 1'b0;
          done   <= 1'b1;
        end
      end

      if (start) begin
        active    <= 1'b1;
        phase_cnt <= '0;
        step      <= '0;
        dur_cnt   <= dur;
      end
      if (stop) begin
        active <= 1'b0;
        level  <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/c16_snd.sv
// Sound unit top: write decode, tone/tick strobe down-counters, four channels and the mixer.
module c16_snd
  import c16_snd_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int CLK_DIV  = 16,
  parameter int TICK_DIV = 50000,
  parameter int OUT_W    = 8
) (
  input  logic              clk,
  input  logic              resetn,
  c16_snd_if.slave          bus,
  output logic [OUT_W-1:0]  sample,
  output logic              sample_valid,
  output logic [NUM_CH-1:0] ch_active,
  output logic [NUM_CH-1:0] done
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int TW = $clog2(TICK_DIV);
  localparam int MW = 6;
  localparam logic [CW-1:0] TONE_LAST = CW'(CLK_DIV - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  logic [CW-1:0]     tone_cnt;
  logic [TW-1:0]     tick_cnt;
  logic              tone_stb, tick_stb, stb_d, wr_ok;
  logic [NUM_CH-1:0] level, active;
  logic [3:0]        vol [NUM_CH];
  logic [MW-1:0]     mix_sum;

  assign tone_stb = (tone_cnt == '0);
  assign tick_stb = (tick_cnt == '0);
  assign wr_ok    = bus.snd_wen && (bus.w_index[10:2] == 9'd0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tone_cnt <= '0;
      tick_cnt <= '0;
    end else begin
      tone_cnt <= tone_stb ? TONE_LAST : tone_cnt - 1'b1;
      tick_cnt <= tick_stb ? TICK_LAST : tick_cnt - 1'b1;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    c16_snd_channel u_ch (
      .clk      (clk),
      .resetn   (resetn),
      .wr       (wr_ok && (bus.w_index[1:0] == 2'(c))),
      .param    (param_e'(bus.w_param)),
      .wdata    (bus.w_val),
      .tone_stb (tone_stb),
      .tick_stb (tick_stb),
      .level    (level[c]),
      .active   (active[c]),
      .done     (done[c]),
      .vol      (vol[c])
    );
  end

  always_comb begin
    mix_sum = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (active[c] && level[c]) mix_sum = mix_sum + MW'(vol[c]);
    end
  end

  // Mix one cycle after the strobe so the sum sees the levels that strobe produced.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stb_d        <= 1'b0;
      sample       <= '0;
      sample_valid <= 1'b0;
    end else begin
      stb_d        <= tone_stb;
      sample_valid <= stb_d;
      if (stb_d) sample <= OUT_W'(mix_sum);
    end
  end

  assign ch_active = active;

endmodule

// File: tb/tb_c16_snd.sv
// Self-checking bench for c16_snd: directed scenarios plus random writes against a behavioural model.
module tb_c16_snd;
  localparam int CD = 4;
  localparam int TD = 64;
  localparam int OW = 8;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [OW-1:0] sample;
  logic          sample_valid;
  logic [3:0]    ch_active, done;

  c16_snd_if bus();

  always #5 clk = ~clk;

  c16_snd #(.NUM_CH(4), .CLK_DIV(CD), .TICK_DIV(TD), .OUT_W(OW)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .bus          (bus.slave),
    .sample       (sample),
    .sample_valid (sample_valid),
    .ch_active    (ch_active),
    .done         (done)
  );

  int n_chk = 0;
  int n_fail = 0;

  int m_per[4], m_vol[4], m_wave[4], m_dur[4], m_act[4], m_lvl[4];
  int m_pc[4], m_step[4], m_lfsr[4], m_dcnt[4], m_done[4];
  int m_sample, m_valid, m_stbd, m_n;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int lfsr_step(input int l);
    return ((l << 1) & 32'h7fff) | (((l >> 14) ^ (l >> 13)) & 1);
  endfunction

  function automatic int tone_level(input int wave, input int step, input int l);
    if (wave == 2) return l & 1;
    if (wave == 1) return (step == 3) ? 1 : 0;
    return step % 2;
  endfunction

  function automatic int pack(input int a[4]);
    int r = 0;
    for (int c = 0; c < 4; c++) if (a[c] != 0) r |= (1 << c);
    return r;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 4; c++) begin
      m_per[c] = 0; m_vol[c] = 0; m_wave[c] = 0; m_dur[c] = 0; m_act[c] = 0;
      m_lvl[c] = 0; m_pc[c] = 0; m_step[c] = 0; m_lfsr[c] = 1; m_dcnt[c] = 0; m_done[c] = 0;
    end
    m_sample = 0; m_valid = 0; m_stbd = 0; m_n = 0;
  endtask

  // Applies one clock edge's worth of behaviour using the inputs present at that edge.
  task automatic model_edge();
    int tone, tick, p, v, s, a, wr, start, stop;
    tone = ((m_n % CD) == 0);
    tick = ((m_n % TD) == 0);
    m_n++;
    if (m_stbd != 0) begin
      s = 0;
      for (int c = 0; c < 4; c++) if (m_act[c] != 0 && m_lvl[c] != 0) s += m_vol[c];
      m_sample = s;
      m_valid = 1;
    end else begin
      m_valid = 0;
    end
    m_stbd = tone;
    p = int'(bus.w_param);
    v = int'(bus.w_val);
    for (int c = 0; c < 4; c++) begin
      m_done[c] = 0;
      wr = (bus.snd_wen === 1'b1) && (bus.w_index[10:2] == 9'd0) && (int'(bus.w_index[1:0]) == c);
      start = wr && p == 3 && (v & 1) != 0 && (v & 2) == 0;
      stop = wr && p == 3 && (v & 2) != 0;
      a = m_act[c];
      if (tone != 0 && a != 0) begin
        if (m_per[c] == 0) m_lvl[c] = 0;
        else if (m_pc[c] != 0) m_pc[c]--;
        else begin
          m_pc[c] = m_per[c] - 1;
          m_step[c] = (m_step[c] + 1) % 4;
          m_lfsr[c] = lfsr_step(m_lfsr[c]);
          m_lvl[c] = tone_level(m_wave[c], m_step[c], m_lfsr[c]);
        end
      end
      if (tick != 0 && a != 0 && m_dur[c] != 0 && m_dcnt[c] != 0) begin
        m_dcnt[c]--;
        if (m_dcnt[c] == 0) begin m_act[c] = 0; m_lvl[c] = 0; m_done[c] = 1; end
      end
      if (start) begin m_act[c] = 1; m_pc[c] = 0; m_step[c] = 0; m_dcnt[c] = m_dur[c]; end
      if (stop) begin m_act[c] = 0; m_lvl[c] = 0; end
      if (wr && p == 0) m_per[c] = v;
      if (wr && p == 1) begin m_vol[c] = v & 15; m_wave[c] = (v >> 4) & 3; end
      if (wr && p == 2) m_dur[c] = v;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_val("sample", 32'(sample), 32'(m_sample));
    check_val("sample_valid", 32'(sample_valid), 32'(m_valid));
    check_val("ch_active", 32'(ch_active), 32'(pack(m_act)));
    check_val("done", 32'(done), 32'(pack(m_done)));
    bus.snd_wen = 1'b0;
    bus.w_param = 2'($urandom_range(3, 0));
    bus.w_index = 11'($urandom);
    bus.w_val   = 16'($urandom);
  endtask

  task automatic wr(input int p, input int idx, input int v);
    bus.snd_wen = 1'b1;
    bus.w_param = 2'(p);
    bus.w_index = 11'(idx);
    bus.w_val   = 16'(v);
    cyc();
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  initial begin
    int cnt, peak, zeros, p, ch, idx, v;
    bus.snd_wen = 1'b0; bus.w_param = '0; bus.w_index = '0; bus.w_val = '0;
    model_reset();
    #12;
    check_val("rst_sample", 32'(sample), 0);
    check_val("rst_valid", 32'(sample_valid), 0);
    check_val("rst_active", 32'(ch_active), 0);
    check_val("rst_done", 32'(done), 0);
    @(negedge clk); resetn = 1'b1;

    // Square on ch0, untimed.
    wr(0, 0, 3); wr(1, 0, 15); wr(2, 0, 0); wr(3, 0, 1);
    check_val("t1_active", 32'(ch_active), 1);
    run(60);

    // Timed note on ch1: exactly one done pulse.
    wr(2, 1, 2); wr(1, 1, 7); wr(0, 1, 2); wr(3, 1, 1);
    cnt = 0;
    for (int i = 0; i < 250; i++) begin cyc(); if (done[1]) cnt++; end
    check_val("t2_done_cnt", 32'(cnt), 1);
    check_val("t2_ch1_off", 32'(ch_active[1]), 0);
    wr(3, 0, 2);

    // All channels pulse25 at full volume.
    for (int c = 0; c < 4; c++) begin wr(0, c, 8); wr(1, c, 15 | (1 << 4)); wr(2, c, 0); end
    for (int c = 0; c < 4; c++) wr(3, c, 1);
    peak = 0; zeros = 0;
    for (int i = 0; i < 400; i++) begin
      cyc();
      if (sample_valid) begin
        if (int'(sample) > peak) peak = int'(sample);
        if (sample == '0) zeros++;
      end
    end
    check_val("t3_peak", 32'(peak), 60);
    check_val("t3_has_zero", 32'(zeros > 0), 1);
    for (int c = 0; c < 4; c++) wr(3, c, 2);

    // Ignored writes: bad index, then snd_wen low with a live start pattern.
    wr(3, 11'h004, 1); wr(0, 11'h7fc, 5);
    bus.w_param = 2'd3; bus.w_index = 11'd0; bus.w_val = 16'd1;
    @(posedge clk); model_edge(); @(negedge clk);
    check_val("t4_no_start", 32'(ch_active), 0);
    wr(3, 0, 1); run(3); wr(3, 0, 3);
    check_val("t4_stop", 32'(ch_active[0]), 0);

    // Period change mid-note.
    wr(0, 0, 3); wr(1, 0, 15); wr(3, 0, 1); run(20); wr(0, 0, 7); run(150);

    // Noise on ch2, then async reset mid-note.
    wr(1, 2, 9 | (2 << 4)); wr(0, 2, 1); wr(3, 2, 1); run(80);
    #2 resetn = 1'b0;
    #1;
    check_val("arst_sample", 32'(sample), 0);
    check_val("arst_valid", 32'(sample_valid), 0);
    check_val("arst_active", 32'(ch_active), 0);
    check_val("arst_done", 32'(done), 0);
    model_reset();
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    wr(1, 2, 9 | (2 << 4)); wr(0, 2, 1); wr(3, 2, 1); run(300);

    // Random traffic, including malformed indices.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(2, 0) == 0) begin
        p = $urandom_range(3, 0);
        ch = $urandom_range(3, 0);
        idx = ($urandom_range(7, 0) == 0) ? (ch | ($urandom_range(511, 1) << 2)) : ch;
        case (p)
          0: v = $urandom_range(6, 0);
          1: v = $urandom_range(63, 0);
          2: v = $urandom_range(4, 0);
          default: v = $urandom_range(3, 0);
        endcase
        wr(p, idx, v);
      end else begin
        cyc();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
